// File: rtl/fp_wb_arbiter.sv
// Round-robin arbiter merging FP execution-unit intermediate results into the
// single normalization/rounding input, with one registered valid/ready stage.
module fp_wb_arbiter #(
   parameter int NUM_WB_UNITS = 4,
   parameter int ID_W = 2,
   parameter int PAYLOAD_W = 128,
   localparam int SRC_W = $clog2(NUM_WB_UNITS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_WB_UNITS-1:0]           unit_done,
   input  logic [NUM_WB_UNITS*ID_W-1:0]      unit_id,
   input  logic [NUM_WB_UNITS*PAYLOAD_W-1:0] unit_payload,
   output logic [NUM_WB_UNITS-1:0]           unit_ack,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ID_W-1:0]                   out_id,
   output logic [PAYLOAD_W-1:0]              out_payload,
   output logic [SRC_W-1:0]                  out_src
);

   logic                 out_valid_q, out_valid_d;
   logic [ID_W-1:0]      out_id_q, out_id_d;
   logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
   logic [SRC_W-1:0]     out_src_q, out_src_d;
   logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;

   logic [ID_W-1:0]      id_a  [NUM_WB_UNITS];
   logic [PAYLOAD_W-1:0] pay_a [NUM_WB_UNITS];

   logic                 load_en;
   logic                 ack_en;
   logic                 gnt_found;
   logic [SRC_W-1:0]     gnt_idx;
   logic [SRC_W-1:0]     rr_nxt;
   logic [SRC_W:0]       cand;

   for (genvar g = 0; g < NUM_WB_UNITS; g++) begin : g_unpack
      assign id_a[g]  = unit_id[g*ID_W +: ID_W];
      assign pay_a[g] = unit_payload[g*PAYLOAD_W +: PAYLOAD_W];
   end

   // Scan starting at rr_ptr; first requester found wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_WB_UNITS; k++) begin
         cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
         if (cand >= (SRC_W+1)'(NUM_WB_UNITS))
            cand = cand - (SRC_W+1)'(NUM_WB_UNITS);
         if (!gnt_found && unit_done[cand[SRC_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[SRC_W-1:0];
         end
      end
   end

   assign load_en = ~out_valid_q | out_ready;
   assign ack_en  = rst & load_en & gnt_found;
   assign rr_nxt  = (gnt_idx == SRC_W'(NUM_WB_UNITS - 1)) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      unit_ack = '0;
      if (ack_en)
         unit_ack[gnt_idx] = 1'b1;
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_id_d      = out_id_q;
      out_payload_d = out_payload_q;
      out_src_d     = out_src_q;
      rr_ptr_d      = rr_ptr_q;
      if (ack_en) begin
         out_valid_d   = 1'b1;
         out_id_d      = id_a[gnt_idx];
         out_payload_d = pay_a[gnt_idx];
         out_src_d     = gnt_idx;
         rr_ptr_d      = rr_nxt;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q   <= 1'b0;
         out_id_q      <= '0;
         out_payload_q <= '0;
         out_src_q     <= '0;
         rr_ptr_q      <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_id_q      <= out_id_d;
         out_payload_q <= out_payload_d;
         out_src_q     <= out_src_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_id      = out_id_q;
   assign out_payload = out_payload_q;
   assign out_src     = out_src_q;

   a_ack_onehot : assert property (
      @(posedge clk) disable iff (!rst) $onehot0(unit_ack));

   a_out_stable : assert property (
      @(posedge clk) disable iff (!rst)
      (out_valid_q & ~out_ready) |=>
         (out_valid_q && $stable(out_id_q) &&
          $stable(out_payload_q) && $stable(out_src_q)));

   // Sources must hold a result until it is acknowledged.
   for (genvar g = 0; g < NUM_WB_UNITS; g++) begin : g_src_chk
      a_done_held : assert property (
         @(posedge clk) disable iff (!rst)
         (unit_done[g] & ~unit_ack[g]) |=> unit_done[g]);
   end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter: reset, latency, round robin, wrap,
// backpressure and mid-operation reset against hand-computed values.
module tb_fp_wb_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int PW = 128;

   logic            clk;
   logic            rst;
   logic [N-1:0]    unit_done;
   logic [N*IW-1:0] unit_id;
   logic [N*PW-1:0] unit_payload;
   logic [N-1:0]    unit_ack;
   logic            out_valid;
   logic            out_ready;
   logic [IW-1:0]   out_id;
   logic [PW-1:0]   out_payload;
   logic [1:0]      out_src;

   logic [PW-1:0]   pay_a [N];
   int              errs;
   int              checks;

   fp_wb_arbiter #(.NUM_WB_UNITS(N), .ID_W(IW), .PAYLOAD_W(PW)) dut (
      .clk          (clk),
      .rst          (rst),
      .unit_done    (unit_done),
      .unit_id      (unit_id),
      .unit_payload (unit_payload),
      .unit_ack     (unit_ack),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_id       (out_id),
      .out_payload  (out_payload),
      .out_src      (out_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign unit_id = {2'd3, 2'd2, 2'd1, 2'd0};

   always_comb begin
      unit_payload = '0;
      for (int i = 0; i < N; i++)
         unit_payload[i*PW +: PW] = pay_a[i];
   end

   task automatic check(input string tag, input logic [PW-1:0] got,
                        input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      unit_done = '0;
      out_ready = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic check_out(input string tag, input int idx);
      check({tag, "_valid"}, PW'(out_valid), PW'(1));
      check({tag, "_src"}, PW'(out_src), PW'(idx));
      check({tag, "_id"}, PW'(out_id), PW'(idx));
      check({tag, "_pay"}, out_payload, pay_a[idx]);
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      for (int i = 0; i < N; i++)
         pay_a[i] = {4{32'h5A5A_0000 + 32'(i)}};

      // reset held with every unit requesting
      rst       = 1'b0;
      unit_done = 4'b1111;
      out_ready = 1'b0;
      step();
      step();
      check("rst_ack", PW'(unit_ack), PW'(0));
      check("rst_valid", PW'(out_valid), PW'(0));
      check("rst_id", PW'(out_id), PW'(0));
      check("rst_pay", out_payload, PW'(0));
      check("rst_src", PW'(out_src), PW'(0));

      // release, then round robin with continuous requests
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("rr_ack%0d", k), PW'(unit_ack), PW'(4'b0001 << (k % N)));
         step();
         check_out($sformatf("rr%0d", k), k % N);
      end

      // single request, then wrap from unit 3 back to 0
      do_reset();
      unit_done = 4'b0100;
      out_ready = 1'b1;
      settle();
      check("single_ack", PW'(unit_ack), PW'(4'b0100));
      step();
      check_out("single", 2);
      unit_done = 4'b1001;
      settle();
      check("wrap_ack3", PW'(unit_ack), PW'(4'b1000));
      step();
      check_out("wrap3", 3);
      unit_done = 4'b0001;
      settle();
      check("wrap_ack0", PW'(unit_ack), PW'(4'b0001));
      step();
      check_out("wrap0", 0);

      // idle cycles drain the output but leave priority at 1
      unit_done = 4'b0000;
      step();
      check("idle_valid", PW'(out_valid), PW'(0));
      check("idle_pay_hold", out_payload, pay_a[0]);
      step();
      unit_done = 4'b0011;
      settle();
      check("idle_ack", PW'(unit_ack), PW'(4'b0010));
      step();
      check_out("idle", 1);
      unit_done = 4'b0001;
      settle();
      check("idle_ack0", PW'(unit_ack), PW'(4'b0001));
      step();
      unit_done = 4'b0000;
      step();

      // backpressure: stall five cycles with units 1 and 3 waiting
      do_reset();
      unit_done = 4'b0001;
      settle();
      check("bp_ack0", PW'(unit_ack), PW'(4'b0001));
      step();
      check_out("bp_load", 0);
      unit_done = 4'b1010;
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("bp_noack%0d", k), PW'(unit_ack), PW'(0));
         check($sformatf("bp_valid%0d", k), PW'(out_valid), PW'(1));
         check($sformatf("bp_pay%0d", k), out_payload, pay_a[0]);
         step();
      end
      out_ready = 1'b1;
      settle();
      check("bp_release_ack", PW'(unit_ack), PW'(4'b0010));
      step();
      check_out("bp_rel", 1);
      unit_done = 4'b1000;
      settle();
      check("bp_ack3", PW'(unit_ack), PW'(4'b1000));
      step();
      check_out("bp3", 3);
      unit_done = 4'b0000;
      step();
      check("drain_valid", PW'(out_valid), PW'(0));
      check("drain_pay_hold", out_payload, pay_a[3]);
      step();
      check("ready_idle_valid", PW'(out_valid), PW'(0));

      // mid-operation reset discards the registered result
      pay_a[2]  = {4{32'hDEAD_BEEF}};
      out_ready = 1'b0;
      unit_done = 4'b0100;
      settle();
      check("mid_ack", PW'(unit_ack), PW'(4'b0100));
      step();
      check_out("mid_load", 2);
      rst       = 1'b0;
      unit_done = 4'b0000;
      step();
      rst = 1'b1;
      check("mid_valid", PW'(out_valid), PW'(0));
      check("mid_pay", out_payload, PW'(0));
      check("mid_id", PW'(out_id), PW'(0));
      check("mid_src", PW'(out_src), PW'(0));
      unit_done = 4'b1111;
      out_ready = 1'b1;
      settle();
      check("mid_rrptr", PW'(unit_ack), PW'(4'b0001));
      step();
      check_out("mid_after", 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
